// File: rtl/div_pkg.sv
// Shared encodings and default sizing for the restoring-divider controller.
package div_pkg;

  localparam int DIV_N     = 4;
  localparam int DIV_CNT_W = 3;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_SHIFT = 3'd2,
    S_SUB   = 3'd3,
    S_TEST  = 3'd4,
    S_DONE  = 3'd5
  } state_e;

endpackage

// File: rtl/iter_counter.sv
// Iteration down-counter: loads the bit count, decrements once per iteration.
// dec_zero flags that the decrement happening this cycle lands on zero.
module iter_counter #(
  parameter int CNT_W = div_pkg::DIV_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             dec_zero
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = load_val;
    else if (dec && (cnt_q != '0))
      cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  // A count of 0 here is unreachable in TEST, but treating it as last keeps the FSM from looping.
  assign dec_zero = (cnt_q <= CNT_W'(1));

endmodule

// File: rtl/restoring_div_ctrl.sv
// Control FSM for an N-bit restoring divider: LOAD, then N x (SHIFT, SUB, TEST), then DONE.
// Strobes decode from the registered state plus a_msb; abort suppresses strobes in its cycle.
module restoring_div_ctrl
  import div_pkg::*;
#(
  parameter int N     = DIV_N,
  parameter int CNT_W = DIV_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic abort,
  input  logic m_zero,
  input  logic a_msb,
  output logic ld_m,
  output logic ld_q,
  output logic clr_a,
  output logic shift_aq,
  output logic ld_a,
  output logic alu_sub,
  output logic q0_wr,
  output logic q0_val,
  output logic busy,
  output logic done,
  output logic div_by_zero
);

  state_e state_q;
  logic   dbz_q;
  logic   cnt_last;

  iter_counter #(
    .CNT_W(CNT_W)
  ) u_iter_counter (
    .clk     (clk),
    .rst     (rst),
    .load    (state_q == S_LOAD),
    .load_val(CNT_W'(N)),
    .dec     ((state_q == S_TEST) && !abort),
    .dec_zero(cnt_last)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      dbz_q   <= 1'b0;
    end else if (abort) begin
      // Abort also beats a simultaneous start in IDLE.
      state_q <= S_IDLE;
      dbz_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          dbz_q <= 1'b0;
          if (start)
            state_q <= S_LOAD;
        end
        S_LOAD: begin
          dbz_q   <= m_zero;
          state_q <= m_zero ? S_DONE : S_SHIFT;
        end
        S_SHIFT: state_q <= S_SUB;
        S_SUB:   state_q <= S_TEST;
        S_TEST:  state_q <= cnt_last ? S_DONE : S_SHIFT;
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    ld_m        = 1'b0;
    ld_q        = 1'b0;
    clr_a       = 1'b0;
    shift_aq    = 1'b0;
    ld_a        = 1'b0;
    alu_sub     = 1'b0;
    q0_wr       = 1'b0;
    q0_val      = 1'b0;
    busy        = (state_q == S_LOAD) || (state_q == S_SHIFT) ||
                  (state_q == S_SUB)  || (state_q == S_TEST);
    done        = (state_q == S_DONE);
    div_by_zero = (state_q == S_DONE) && dbz_q;
    if (!abort) begin
      case (state_q)
        S_LOAD: begin
          ld_m  = 1'b1;
          ld_q  = 1'b1;
          clr_a = 1'b1;
        end
        S_SHIFT: shift_aq = 1'b1;
        S_SUB: begin
          ld_a    = 1'b1;
          alu_sub = 1'b1;
        end
        S_TEST: begin
          // Negative remainder: add M back (alu_sub=0) and record a 0 quotient bit.
          q0_wr  = 1'b1;
          q0_val = !a_msb;
          ld_a   = a_msb;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_restoring_div_ctrl.sv
// Directed bench: drives the controller against a behavioural A/Q/M datapath and checks results.
module tb_restoring_div_ctrl;

  logic clk = 1'b0;
  logic rst, start, abort;
  logic ld_m, ld_q, clr_a, shift_aq, ld_a, alu_sub, q0_wr, q0_val;
  logic busy, done, div_by_zero;

  logic [3:0] dvd, dvs;
  logic [4:0] A;
  logic [3:0] Q, M;
  logic       m_zero, a_msb;

  int n_assert = 0;
  int n_fail   = 0;
  int edge_no  = 0;

  int busy_cnt, first_busy, last_busy, shift_cnt, restore_cnt, excl_cnt;
  int done_cnt, done_edge, dbz_at_done, dbz_stray;

  assign m_zero = (dvs == 4'd0);
  assign a_msb  = A[4];

  restoring_div_ctrl #(.N(4), .CNT_W(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .m_zero     (m_zero),
    .a_msb      (a_msb),
    .ld_m       (ld_m),
    .ld_q       (ld_q),
    .clr_a      (clr_a),
    .shift_aq   (shift_aq),
    .ld_a       (ld_a),
    .alu_sub    (alu_sub),
    .q0_wr      (q0_wr),
    .q0_val     (q0_val),
    .busy       (busy),
    .done       (done),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  // Behavioural datapath: A is one bit wider than Q so the subtract sign is visible.
  always @(posedge clk) begin
    if (ld_m) M <= dvs;
    if (ld_q) Q <= dvd;
    if (clr_a) A <= 5'd0;
    if (shift_aq) {A, Q} <= {A[3:0], Q, 1'b0};
    if (ld_a) A <= alu_sub ? (A - {1'b0, M}) : (A + {1'b0, M});
    if (q0_wr) Q[0] <= q0_val;
  end

  always @(negedge clk) begin
    if (busy) begin
      busy_cnt++;
      last_busy = edge_no;
      if (first_busy == 0) first_busy = edge_no;
    end
    if (shift_aq) shift_cnt++;
    if (ld_a && !alu_sub) restore_cnt++;
    if (shift_aq && ld_a) excl_cnt++;
    if (done) begin
      done_cnt++;
      done_edge   = edge_no;
      dbz_at_done = int'(div_by_zero);
    end
    if (div_by_zero && !done) dbz_stray++;
  end

  function automatic logic [10:0] outs();
    return {ld_m, ld_q, clr_a, shift_aq, ld_a, alu_sub, q0_wr, q0_val, busy, done, div_by_zero};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    edge_no++;
  endtask

  task automatic clear_mon();
    edge_no = 0; busy_cnt = 0; first_busy = 0; last_busy = 0; shift_cnt = 0;
    restore_cnt = 0; excl_cnt = 0; done_cnt = 0; done_edge = 0; dbz_at_done = 0; dbz_stray = 0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Full division from IDLE; edge 1 is the edge that samples start.
  task automatic run_div(input string tag, input logic [3:0] a, input logic [3:0] b,
                         input int exp_q, input int exp_a, input int exp_restore,
                         input int exp_done_edge, input int exp_shift, input int exp_dbz);
    clear_mon();
    dvd = a; dvs = b; start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "_load_strobes"}, {29'd0, ld_m, ld_q, clr_a}, 32'd7);
    repeat (15) tick();
    check({tag, "_q"}, {28'd0, Q}, exp_q);
    check({tag, "_a"}, {27'd0, A}, exp_a);
    check({tag, "_done_edge"}, done_edge, exp_done_edge);
    check({tag, "_done_pulses"}, done_cnt, 1);
    check({tag, "_dbz"}, dbz_at_done, exp_dbz);
    check({tag, "_busy_first"}, first_busy, 1);
    check({tag, "_busy_last"}, last_busy, exp_done_edge - 1);
    check({tag, "_busy_cycles"}, busy_cnt, exp_done_edge - 1);
    check({tag, "_shifts"}, shift_cnt, exp_shift);
    check({tag, "_restores"}, restore_cnt, exp_restore);
    check({tag, "_excl"}, excl_cnt, 0);
    check({tag, "_dbz_stray"}, dbz_stray, 0);
    check({tag, "_idle_after"}, {21'd0, outs()}, 0);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; abort = 1'b0; dvd = 4'd0; dvs = 4'd1;
    clear_mon();
    tick();
    tick();
    check("reset_outs", {21'd0, outs()}, 0);
    #2 rst = 1'b1;
    tick();
    check("idle_outs", {21'd0, outs()}, 0);

    run_div("d13_4", 4'd13, 4'd4, 3, 1, 2, 14, 4, 0);
    run_div("d15_1", 4'd15, 4'd1, 15, 0, 0, 14, 4, 0);
    run_div("d7_9", 4'd7, 4'd9, 0, 7, 4, 14, 4, 0);
    run_div("d9_0", 4'd9, 4'd0, 9, 0, 0, 2, 0, 1);

    // start re-pulsed in SUB and DONE is ignored; held into IDLE it is taken
    clear_mon();
    dvd = 4'd13; dvs = 4'd4; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("rs_sub_strobes", {30'd0, ld_a, alu_sub}, 3);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("rs_after_sub_q0wr", {31'd0, q0_wr}, 1);
    check("rs_after_sub_ldm", {31'd0, ld_m}, 0);
    repeat (10) tick();
    check("rs_done_e14", {31'd0, done}, 1);
    start = 1'b1;
    tick();
    check("rs_ignored_in_done", {29'd0, busy, ld_m, done}, 0);
    tick();
    start = 1'b0;
    check("rs_new_load", {30'd0, ld_m, busy}, 3);
    repeat (14) tick();
    check("rs_done_count", done_cnt, 2);
    check("rs_second_done_edge", done_edge, 29);
    check("rs_q", {28'd0, Q}, 3);

    // abort in the second SHIFT
    clear_mon();
    dvd = 4'd13; dvs = 4'd4; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    check("ab_in_shift", {31'd0, shift_aq}, 1);
    abort = 1'b1;
    #1;
    check("ab_no_strobe", {26'd0, ld_m, ld_q, clr_a, shift_aq, ld_a, q0_wr}, 0);
    tick();
    abort = 1'b0;
    check("ab_idle", {21'd0, outs()}, 0);
    repeat (20) tick();
    check("ab_no_done", done_cnt, 0);
    check("ab_shifts", shift_cnt, 1);
    abort = 1'b1; start = 1'b1;
    tick();
    abort = 1'b0; start = 1'b0;
    check("ab_wins_over_start", {30'd0, busy, ld_m}, 0);
    tick();
    check("ab_still_idle", {31'd0, busy}, 0);

    // asynchronous reset pulse during TEST
    clear_mon();
    dvd = 4'd13; dvs = 4'd4; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    check("rst_in_test", {30'd0, q0_wr, busy}, 3);
    #2 rst = 1'b0;
    #1;
    check("rst_async_outs", {21'd0, outs()}, 0);
    #2 rst = 1'b1;
    repeat (20) tick();
    check("rst_no_done", done_cnt, 0);
    check("rst_idle", {31'd0, busy}, 0);

    // first edge after reset release samples start
    #2 rst = 1'b0;
    clear_mon();
    dvd = 4'd15; dvs = 4'd1; start = 1'b1;
    #2 rst = 1'b1;
    tick();
    start = 1'b0;
    check("rst_first_edge_load", {30'd0, ld_m, busy}, 3);
    repeat (14) tick();
    check("rst_run_done_edge", done_edge, 14);
    check("rst_run_q", {28'd0, Q}, 15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
